// File: rtl/instr_memory.sv
// Instruction memory for the single-cycle RISC-V core: combinational read,
// synchronous program-load port, and an asynchronous reset back to the boot image.
module instr_memory #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       address,
    output logic [WIDTH-1:0] instruction,
    output logic             misaligned,
    input  logic             prog_we,
    input  logic [7:0]       prog_addr,
    input  logic [WIDTH-1:0] prog_wdata
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];

    // Boot program: arithmetic demo, a store/load pair, then a branch-to-self halt.
    function automatic logic [WIDTH-1:0] boot_word(input int idx);
        case (idx)
            0:       boot_word = 32'h0050_0093;
            1:       boot_word = 32'h00A0_0113;
            2:       boot_word = 32'h0020_81B3;
            3:       boot_word = 32'h4020_8233;
            4:       boot_word = 32'h0020_F2B3;
            5:       boot_word = 32'h0020_E333;
            6:       boot_word = 32'h0030_2023;
            7:       boot_word = 32'h0000_2403;
            8:       boot_word = 32'h0000_0063;
            default: boot_word = 32'h0000_0013;
        endcase
    endfunction

    // Reset dominates any coincident load, so a write during reset is discarded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= boot_word(i);
            end
        end else if (prog_we) begin
            mem[prog_addr[AW+1:2]] <= prog_wdata;
        end
    end

    assign instruction = mem[address[AW+1:2]];
    assign misaligned  = |address[1:0];

endmodule

// File: tb/tb_instr_memory.sv
// Self-checking bench for instr_memory: directed test-plan steps followed by
// randomized loads/reads compared against a word-array reference model.
module tb_instr_memory;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [7:0]  address = 8'h00;
    logic [31:0] instruction;
    logic        misaligned;
    logic        prog_we = 1'b0;
    logic [7:0]  prog_addr = 8'h00;
    logic [31:0] prog_wdata = 32'h0;

    int n_checks = 0;
    int n_fail = 0;

    logic [31:0] model [64];

    instr_memory dut (
        .clk(clk),
        .rst_n(rst_n),
        .address(address),
        .instruction(instruction),
        .misaligned(misaligned),
        .prog_we(prog_we),
        .prog_addr(prog_addr),
        .prog_wdata(prog_wdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] spec_default(input int byte_addr);
        case (byte_addr)
            'h00:    return 32'h00500093;
            'h04:    return 32'h00A00113;
            'h08:    return 32'h002081B3;
            'h0C:    return 32'h40208233;
            'h10:    return 32'h0020F2B3;
            'h14:    return 32'h0020E333;
            'h18:    return 32'h00302023;
            'h1C:    return 32'h00002403;
            'h20:    return 32'h00000063;
            default: return 32'h00000013;
        endcase
    endfunction

    task automatic model_reset();
        for (int w = 0; w < 64; w++) model[w] = spec_default(w * 4);
    endtask

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic read_check(input string tag, input logic [7:0] a);
        address = a;
        #1;
        check32(tag, instruction, model[a / 4]);
        check1({tag, "_mis"}, misaligned, (a % 4) != 0);
    endtask

    initial begin
        logic [7:0]  ra;
        logic [7:0]  wa;
        logic [31:0] wd;
        logic        we;

        // Reset pulse and sweep of the boot image
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        #2;
        rst_n = 1'b1;
        read_check("rd00", 8'h00);
        check32("rd00_const", instruction, 32'h00500093);
        read_check("rd04", 8'h04);
        check32("rd04_const", instruction, 32'h00A00113);
        read_check("rd08", 8'h08);
        check32("rd08_const", instruction, 32'h002081B3);
        read_check("rd12_mis", 8'h12);
        check32("rd12_const", instruction, 32'h0020F2B3);
        read_check("rd16_mis", 8'h16);
        check32("rd16_const", instruction, 32'h0020E333);
        read_check("rd20", 8'h20);
        check32("rd20_const", instruction, 32'h00000063);
        read_check("rd24", 8'h24);
        read_check("rdFC", 8'hFC);
        check32("rdFC_const", instruction, 32'h00000013);

        // Program load: old value before the edge, new value after it
        @(negedge clk);
        prog_we = 1'b1;
        prog_addr = 8'h24;
        prog_wdata = 32'hDEADBEEF;
        read_check("load_before", 8'h24);
        @(posedge clk);
        #1;
        prog_we = 1'b0;
        model[9] = 32'hDEADBEEF;
        check32("load_after", instruction, 32'hDEADBEEF);

        // Asynchronous reset mid-cycle restores immediately
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check32("async_reset", instruction, 32'h00000013);

        // Write attempted while reset is held is discarded
        prog_we = 1'b1;
        prog_addr = 8'h00;
        prog_wdata = 32'h12345678;
        @(posedge clk);
        #1;
        prog_we = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        read_check("wr_in_reset", 8'h00);
        check32("wr_in_reset_const", instruction, 32'h00500093);

        // Last of consecutive writes to one word wins (byte offset ignored)
        @(negedge clk);
        prog_we = 1'b1;
        prog_addr = 8'h41;
        prog_wdata = 32'hAAAA5555;
        @(negedge clk);
        prog_addr = 8'h43;
        prog_wdata = 32'h0BADF00D;
        @(negedge clk);
        prog_we = 1'b0;
        model[16] = 32'h0BADF00D;
        read_check("last_write", 8'h40);

        // Randomized loads, reads and occasional reset pulses
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            ra = 8'($urandom);
            wa = 8'($urandom);
            wd = $urandom;
            we = ($urandom_range(0, 2) != 0);
            prog_we = we;
            prog_addr = wa;
            prog_wdata = wd;
            read_check("rand_pre", ra);
            @(posedge clk);
            #1;
            if (we) model[wa / 4] = wd;
            prog_we = 1'b0;
            read_check("rand_post", wa);
            if ($urandom_range(0, 39) == 0) begin
                rst_n = 1'b0;
                model_reset();
                read_check("rand_reset", ra);
                #1;
                rst_n = 1'b1;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
